keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Multiplexed 4x4 hex keypad scanner for board input.
- Drives one active-low column at a time and samples four active-low row lines.
- Debounces whole-keypad snapshots and emits one 4-bit key code per press over a valid/ready handshake.
- Shifts accepted codes into a DW-bit value register for the pipeline or UART path.
- Sits at the board I/O boundary as the input-side counterpart of the seven-segment display driver.

## Interface
- DW, 32: width of value_o; must be a multiple of 4, at least 8.
- SCAN_DIV, 131072: clock cycles per column slot; at least 4.
- DEBOUNCE, 4: consecutive identical full-sweep snapshots required for acceptance; at least 1.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- col_o  output  4  column drive, active-low, exactly one bit low.
- row_i  input  4  row sense, active-low, asynchronous to clk.
- key_valid_o  output  1  key code available.
- key_code_o  output  4  key code, `{row[1:0], col[1:0]}`.
- key_ready_i  input  1  consumer accepts the code.
- value_o  output  DW  shift register of accepted codes, newest code in [3:0].
- overrun_o  output  1  sticky flag: a press was lost because a code was still pending.
- clear_i  input  1  clears value_o, overrun_o and any pending code.

## Operation
- row_i passes through a 2-flop synchronizer before any use.
- Slot counter:
  - Counts 0..SCAN_DIV-1.
  - On its last count (the slot tick), the synchronized rows are captured for the current column.
  - The column then advances 0→1→2→3→0 (wrap). col_o is `~(1<<col)`.
- Sweep snapshot:
  - Four captures form a 16-bit snapshot; bit `row*4+col` is 1 when that key is pressed (row sampled low).
  - The snapshot completes at the column-3 tick.
- Debounce:
  - If snapshot == previous snapshot, the stable counter increments, saturating at DEBOUNCE.
  - Otherwise the counter resets to 1 and the previous snapshot is updated.
  - The snapshot is stable when the counter reaches DEBOUNCE.
- FSM states, evaluated only on sweep completion:
  - IDLE: stable snapshot with exactly one bit set → EMIT; stable with more than one bit set → HOLD (chord ignored); otherwise stay.
  - EMIT (one clk cycle): if no code is pending, load key_code_o and set key_valid_o; else set overrun_o. Then → HOLD.
  - HOLD: stable all-zero snapshot → IDLE; any other snapshot stays in HOLD.
- Handshake:
  - key_valid_o stays high, with key_code_o constant, until a cycle where key_valid_o && key_ready_i.
  - In that cycle key_valid_o clears next edge and value_o <= {value_o[DW-5:0], key_code_o}.
  - There is a one-entry buffer only; a new press while a code is pending is dropped.
- clear_i:
  - Next edge: value_o=0, overrun_o=0, key_valid_o=0.
  - Scan, debounce and FSM are unaffected.
  - clear_i wins over a simultaneous handshake (no shift) and over a simultaneous EMIT (code dropped, overrun not set).

## Timing
- Reset values (reset low at an edge):
  - col_o=4'b1110, key_valid_o=0, key_code_o=0, value_o=0, overrun_o=0.
  - FSM=IDLE, slot=0, column=0, stable counter=0, previous snapshot=0.
  - Synchronizer flops reset to 4'b1111 (released).
- Reset mid-scan or mid-handshake aborts everything to the values above; a pending code is lost.
- One sweep = 4*SCAN_DIV cycles.
- Press latency:
  - key_valid_o rises on the cycle after the EMIT state.
  - EMIT is entered on the edge after the sweep completion that reaches DEBOUNCE.
  - A press that is steady from a sweep boundary therefore emits after DEBOUNCE sweeps + 2 cycles, plus sync delay.
- Acceptance: value_o updates on the edge of the handshake cycle; key_ready_i is combinationally unused otherwise.
- A press shorter than DEBOUNCE sweeps is never emitted.
- A release shorter than DEBOUNCE sweeps does not return the FSM to IDLE.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In HOLD, with a stable single-key snapshot equal to the emitted key, a repeat EMIT of the same code occurs.
  - The first repeat comes 32 sweeps after the original EMIT, then every 8 sweeps while held.
  - The repeat counter resets on leaving HOLD.
  - Repeats obey the pending/overrun rules.
- Undefined: exactly one emission per press; the repeat counter logic is absent.

## Test plan
- Reset with SCAN_DIV=4, DEBOUNCE=2, reset=0 for 3 cycles → all outputs at reset values, col_o cycles 1110,1101,1011,0111 every 4 cycles after release.
- Hold row 2 low while column 1 is driven, for 3 sweeps, with key_ready_i=1 → single key_valid_o pulse with key_code_o=4'h9; value_o=32'h00000009; no second pulse until release.
- With key_ready_i=0, press key 4'h9 and release, then press key 4'h3 → key_valid_o stays high with 4'h9, overrun_o=1; after ready, value_o=32'h9.
- Bounce on key 4'h5 toggling every sweep for 6 sweeps → no emission; after 2 stable sweeps, exactly one 4'h5.
- Press rows 0 and 1 of column 0 together → no emission; release, then press 4'hA → value_o shifts in 4'hA only.
- clear_i asserted in the same cycle as valid && ready → value_o=0, overrun_o=0, key_valid_o=0 next cycle; with KEYPAD_AUTOREPEAT_EN, holding 4'h7 for 50 sweeps at ready=1 → 4 codes (sweeps 0, 32, 40, 48 after first EMIT).

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad scanner.
// Drives one active-low column at a time and samples the active-low rows. Whole-keypad
// snapshots are debounced, and each press produces one 4-bit code {row, col} on a
// valid/ready handshake. Accepted codes are shifted into value_o, newest in [3:0].
// Optional feature: define KEYPAD_AUTOREPEAT_EN to repeat a held single key (first repeat
// 32 sweeps after the original emission, then every 8 sweeps).
module keypad_scanner #(
  parameter int unsigned DW       = 32,
  parameter int unsigned SCAN_DIV = 131072,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic [3:0]    col_o,
  input  logic [3:0]    row_i,
  output logic          key_valid_o,
  output logic [3:0]    key_code_o,
  input  logic          key_ready_i,
  output logic [DW-1:0] value_o,
  output logic          overrun_o,
  input  logic          clear_i
);

  localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);

  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StHold
  } state_t;

  // ---------------------------------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------------------------------
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  // Two-flop synchronizer; released (all-high) rows after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_i;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Column slot timing
  // ---------------------------------------------------------------------------------------
  logic [SlotW-1:0] slot;
  logic [1:0]       col;
  logic             slot_tick;
  logic             sweep_done;

  assign slot_tick  = (slot == SlotLast);
  assign sweep_done = slot_tick && (col == 2'd3);
  assign col_o      = ~(4'b0001 << col);

  // Slot counter and column pointer; the column advances after its capture tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot <= '0;
      col  <= 2'd0;
    end else if (slot_tick) begin
      slot <= '0;
      col  <= col + 2'd1;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Sweep snapshot
  // ---------------------------------------------------------------------------------------
  logic [15:0] snap_acc;
  logic [15:0] snap_now;

  // Merge the current column's rows into the accumulated snapshot; at the column-3 tick
  // this is the complete sweep snapshot.
  always_comb begin
    snap_now = snap_acc;
    for (int r = 0; r < 4; r++) begin
      snap_now[r*4 + int'(col)] = ~row_sync[r];
    end
  end

  // Capture the current column's rows on each slot tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_acc <= '0;
    end else if (slot_tick) begin
      snap_acc <= snap_now;
    end
  end

  // Snapshot classification and key encoding (bit index row*4+col is the code).
  logic       snap_zero;
  logic       snap_single;
  logic [3:0] code_now;

  assign snap_zero   = (snap_now == 16'h0000);
  assign snap_single = !snap_zero && ((snap_now & (snap_now - 16'h0001)) == 16'h0000);

  // Priority encoder; only meaningful when exactly one bit is set.
  always_comb begin
    code_now = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (snap_now[i]) begin
        code_now = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------------------
  logic [15:0]     prev_snap;
  logic [CntW-1:0] stable_cnt;
  logic [CntW-1:0] stable_cnt_next;
  logic            snap_same;
  logic            stable_now;

  assign snap_same = (snap_now == prev_snap);

  // Saturating count of consecutive identical snapshots; a change restarts at one.
  always_comb begin
    stable_cnt_next = CntOne;
    if (snap_same) begin
      stable_cnt_next = (stable_cnt == CntMax) ? stable_cnt : stable_cnt + 1'b1;
    end
  end

  // Stability as seen by the FSM at the sweep completion that produces it.
  assign stable_now = sweep_done && (stable_cnt_next == CntMax);

  // Debounce state advances once per completed sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable_cnt <= '0;
      prev_snap  <= '0;
    end else if (sweep_done) begin
      stable_cnt <= stable_cnt_next;
      if (!snap_same) begin
        prev_snap <= snap_now;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Press FSM
  // ---------------------------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic [3:0] emit_code;
  logic       repeat_fire;
  logic       emit_active;
  logic       load_code;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: decisions only happen on a stable snapshot at sweep completion.
  always_comb begin
    state_next = state;
    case (state)
      StIdle: begin
        if (stable_now) begin
          if (snap_single) begin
            state_next = StEmit;
          end else if (!snap_zero) begin
            state_next = StHold;  // chord: wait for full release
          end
        end
      end
      StEmit: begin
        state_next = StHold;
      end
      StHold: begin
        if (stable_now && snap_zero) begin
          state_next = StIdle;
        end else if (repeat_fire) begin
          state_next = StEmit;
        end
      end
      default: begin
        state_next = StIdle;
      end
    endcase
  end

  // FSM decoded outputs.
  always_comb begin
    emit_active = (state == StEmit);
    load_code   = (state == StIdle) && (state_next == StEmit);
  end

  // Latch the key code as the FSM commits to emitting it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      emit_code <= 4'h0;
    end else if (load_code) begin
      emit_code <= code_now;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // ---------------------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------------------
  logic [5:0] rep_cnt;
  logic [5:0] rep_cnt_next;
  logic [5:0] rep_limit;
  logic       rep_first;

  assign rep_cnt_next = (rep_cnt == 6'd63) ? rep_cnt : rep_cnt + 6'd1;
  assign rep_limit    = rep_first ? 6'd32 : 6'd8;
  assign repeat_fire  = stable_now && snap_single && (code_now == emit_code) &&
                        (rep_cnt_next >= rep_limit);

  // Sweeps spent in HOLD since the last emission; rep_first selects the long first delay.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt   <= 6'd0;
      rep_first <= 1'b1;
    end else begin
      if (state == StHold) begin
        if (sweep_done) begin
          rep_cnt <= rep_cnt_next;
        end
        if (repeat_fire) begin
          rep_first <= 1'b0;
        end
      end else begin
        rep_cnt <= 6'd0;
        if (state == StIdle) begin
          rep_first <= 1'b1;
        end
      end
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------
  // Output buffer, handshake and value register
  // ---------------------------------------------------------------------------------------
  // One-entry code buffer; clear beats both a handshake and an emission.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_valid_o <= 1'b0;
      key_code_o  <= 4'h0;
      value_o     <= '0;
      overrun_o   <= 1'b0;
    end else if (clear_i) begin
      key_valid_o <= 1'b0;
      value_o     <= '0;
      overrun_o   <= 1'b0;
    end else begin
      if (key_valid_o && key_ready_i) begin
        key_valid_o <= 1'b0;
        value_o     <= {value_o[DW-5:0], key_code_o};
      end
      if (emit_active) begin
        if (!key_valid_o) begin
          key_valid_o <= 1'b1;
          key_code_o  <= emit_code;
        end else begin
          overrun_o <= 1'b1;  // code still pending: press is dropped
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (one sweep = 16 cycles).
// The keypad is modelled as a 16-bit set of pressed keys shorting rows to driven columns.
module tb_keypad_scanner;

  localparam int unsigned DW    = 32;
  localparam int          Sweep = 16;

  logic          clk;
  logic          reset;
  logic [3:0]    col_o;
  logic [3:0]    row_i;
  logic          key_valid_o;
  logic [3:0]    key_code_o;
  logic          key_ready_i;
  logic [DW-1:0] value_o;
  logic          overrun_o;
  logic          clear_i;

  logic [15:0] keys;
  int          n_vec;
  int          n_err;
  int          hs_count;
  int          h0;
  logic [3:0]  col_exp [4];

  keypad_scanner #(
    .DW       (DW),
    .SCAN_DIV (4),
    .DEBOUNCE (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .col_o       (col_o),
    .row_i       (row_i),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .key_ready_i (key_ready_i),
    .value_o     (value_o),
    .overrun_o   (overrun_o),
    .clear_i     (clear_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a row reads low if any pressed key in it sits on a driven column.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_i[r] = ~|(keys[r*4 +: 4] & ~col_o);
    end
  end

  // Count accepted handshakes as the consumer sees them.
  initial hs_count = 0;
  always @(posedge clk) begin
    if (reset && !clear_i && key_valid_o && key_ready_i) begin
      hs_count <= hs_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_sweeps(input int n);
    repeat (n * Sweep) @(negedge clk);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    keys        = 16'h0000;
    reset       = 1'b0;
    key_ready_i = 1'b0;
    clear_i     = 1'b0;
    col_exp[0]  = 4'b1110;
    col_exp[1]  = 4'b1101;
    col_exp[2]  = 4'b1011;
    col_exp[3]  = 4'b0111;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", 32'(col_o), 32'h0000_000E);
    check("rst_valid", 32'(key_valid_o), 32'h0);
    check("rst_code", 32'(key_code_o), 32'h0);
    check("rst_value", value_o, 32'h0);
    check("rst_overrun", 32'(overrun_o), 32'h0);

    // Column rotation, four cycles per column
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("col_seq", 32'(col_o), 32'(col_exp[i]));
      repeat (4) @(negedge clk);
    end
    check("col_wrap", 32'(col_o), 32'h0000_000E);

    // Single press of key 9 (row 2, column 1) with ready high
    key_ready_i = 1'b1;
    h0 = hs_count;
    keys = 16'h0200;
    run_sweeps(5);
    check("press9_hs", 32'(hs_count - h0), 32'd1);
    check("press9_value", value_o, 32'h0000_0009);
    check("press9_code", 32'(key_code_o), 32'h9);
    run_sweeps(6);
    check("press9_nodup", 32'(hs_count - h0), 32'd1);
    keys = 16'h0000;
    run_sweeps(4);

    // Pending code with ready low; a second press overruns
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("clr_value", value_o, 32'h0);
    key_ready_i = 1'b0;
    keys = 16'h0200;
    run_sweeps(5);
    check("pend_valid", 32'(key_valid_o), 32'h1);
    keys = 16'h0000;
    run_sweeps(4);
    keys = 16'h0008;
    run_sweeps(5);
    keys = 16'h0000;
    run_sweeps(4);
    check("ovr_valid", 32'(key_valid_o), 32'h1);
    check("ovr_code", 32'(key_code_o), 32'h9);
    check("ovr_flag", 32'(overrun_o), 32'h1);
    key_ready_i = 1'b1;
    @(negedge clk);
    key_ready_i = 1'b0;
    check("ovr_value", value_o, 32'h0000_0009);
    check("ovr_valid_clr", 32'(key_valid_o), 32'h0);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("clr_overrun", 32'(overrun_o), 32'h0);

    // Bounce on key 5, toggling every sweep
    key_ready_i = 1'b1;
    h0 = hs_count;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      run_sweeps(1);
    end
    check("bounce_none", 32'(hs_count - h0), 32'd0);
    keys = 16'h0020;
    run_sweeps(5);
    check("bounce_one", 32'(hs_count - h0), 32'd1);
    check("bounce_value", value_o, 32'h0000_0005);
    keys = 16'h0000;
    run_sweeps(4);

    // Chord on column 0 rows 0 and 1 is ignored, then key A
    h0 = hs_count;
    keys = 16'h0011;
    run_sweeps(5);
    check("chord_none", 32'(hs_count - h0), 32'd0);
    keys = 16'h0000;
    run_sweeps(4);
    keys = 16'h0400;
    run_sweeps(5);
    check("keyA_hs", 32'(hs_count - h0), 32'd1);
    check("keyA_value", value_o, 32'h0000_005A);
    keys = 16'h0000;
    run_sweeps(4);

    // Clear in the same cycle as a handshake, with overrun set
    key_ready_i = 1'b0;
    keys = 16'h0040;
    run_sweeps(5);
    keys = 16'h0000;
    run_sweeps(4);
    keys = 16'h1000;
    run_sweeps(5);
    keys = 16'h0000;
    run_sweeps(4);
    check("pre_clr_valid", 32'(key_valid_o), 32'h1);
    check("pre_clr_overrun", 32'(overrun_o), 32'h1);
    key_ready_i = 1'b1;
    clear_i     = 1'b1;
    @(negedge clk);
    key_ready_i = 1'b0;
    clear_i     = 1'b0;
    check("clrhs_value", value_o, 32'h0);
    check("clrhs_overrun", 32'(overrun_o), 32'h0);
    check("clrhs_valid", 32'(key_valid_o), 32'h0);

    // Reset while a code is pending
    keys = 16'h0002;
    run_sweeps(5);
    check("pend1_valid", 32'(key_valid_o), 32'h1);
    check("pend1_code", 32'(key_code_o), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_valid", 32'(key_valid_o), 32'h0);
    check("rst2_code", 32'(key_code_o), 32'h0);
    check("rst2_col", 32'(col_o), 32'h0000_000E);
    reset = 1'b1;
    keys  = 16'h0000;
    run_sweeps(4);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat on a long hold of key 7
    key_ready_i = 1'b1;
    h0 = hs_count;
    keys = 16'h0080;
    for (int i = 0; i < 6 * Sweep && hs_count == h0; i++) begin
      @(negedge clk);
    end
    check("rep_first", 32'(hs_count - h0), 32'd1);
    run_sweeps(50);
    check("rep_count", 32'(hs_count - h0), 32'd4);
    check("rep_value", value_o, 32'h0000_7777);
    keys = 16'h0000;
    run_sweeps(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
